// File: rtl/logic_arb_pkg.sv
// Shared opcode/state types and widths for the logic-op arbiter.
package logic_arb_pkg;

   localparam int unsigned OPW      = 3;
   localparam int unsigned RSP_ID_W = 3;

   typedef enum logic [OPW-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOTA = 3'd6,
      OP_RSVD = 3'd7
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise logic unit; the reserved opcode yields zero with err set.
module logic_unit
   import logic_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             err
);

   always_comb begin
      y   = '0;
      err = 1'b0;
      case (op_e'(op))
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XNOR: y = ~(a ^ b);
         OP_NOTA: y = ~a;
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/logic_op_arbiter.sv
// Arbitrates NUM_REQ requesters onto one logic_unit with a single-entry output register.
// Define LOGIC_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index first.
module logic_op_arbiter
   import logic_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*OPW-1:0]   req_op,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WIDTH-1:0]         rsp_data,
   output logic [RSP_ID_W-1:0]      rsp_id,
   output logic                     rsp_err
);

   localparam int unsigned IDXW = $clog2(NUM_REQ);

   state_e                state_q, state_d;
   logic [WIDTH-1:0]      rsp_data_q, rsp_data_d;
   logic [RSP_ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic                  rsp_err_q, rsp_err_d;

   logic [IDXW-1:0]       base_c;
   logic [IDXW-1:0]       grant_idx_c;
   logic                  found_c;
   logic                  grant_ok_c;
   logic                  transfer_c;
   logic [OPW-1:0]        sel_op_c;
   logic [WIDTH-1:0]      sel_a_c, sel_b_c;
   logic [WIDTH-1:0]      lu_y_c;
   logic                  lu_err_c;

`ifdef LOGIC_ARB_RR_EN
   logic [IDXW-1:0]       ptr_q, ptr_d;

   assign base_c = ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (transfer_c) begin
         ptr_d = (grant_idx_c == IDXW'(NUM_REQ - 1)) ? '0 : grant_idx_c + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
`else
   assign base_c = '0;
`endif

   // First valid requester searching upward from base_c, wrapping at NUM_REQ.
   always_comb begin
      int unsigned cand;
      cand        = 0;
      found_c     = 1'b0;
      grant_idx_c = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = 32'(base_c) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!found_c && req_valid[IDXW'(cand)]) begin
            found_c     = 1'b1;
            grant_idx_c = IDXW'(cand);
         end
      end
   end

   assign grant_ok_c = (state_q == ST_IDLE) || rsp_ready;
   assign transfer_c = rst_n && grant_ok_c && found_c;

   always_comb begin
      req_ready = '0;
      if (transfer_c) req_ready[grant_idx_c] = 1'b1;
   end

   always_comb begin
      sel_op_c = '0;
      sel_a_c  = '0;
      sel_b_c  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_idx_c == IDXW'(i)) begin
            sel_op_c = req_op[i*OPW +: OPW];
            sel_a_c  = req_a[i*WIDTH +: WIDTH];
            sel_b_c  = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
      .op  (sel_op_c),
      .a   (sel_a_c),
      .b   (sel_b_c),
      .y   (lu_y_c),
      .err (lu_err_c)
   );

   // A transfer always reloads the output register, so HOLD+ready+transfer stays in HOLD.
   always_comb begin
      state_d    = state_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      rsp_err_d  = rsp_err_q;
      case (state_q)
         ST_IDLE: if (transfer_c) state_d = ST_HOLD;
         ST_HOLD: if (rsp_ready && !transfer_c) state_d = ST_IDLE;
      endcase
      if (transfer_c) begin
         rsp_data_d = lu_y_c;
         rsp_id_d   = RSP_ID_W'(grant_idx_c);
         rsp_err_d  = lu_err_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rsp_data_q <= '0;
         rsp_id_q   <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign rsp_valid = (state_q == ST_HOLD);
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: directed vectors, corner sequences and random traffic vs. a reference model.
module tb_logic_op_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned WIDTH   = 8;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*3-1:0]     req_op;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [WIDTH-1:0]         rsp_data;
   logic [2:0]               rsp_id;
   logic                     rsp_err;

   int checks   = 0;
   int failures = 0;

   // Reference model state: one pending result slot plus priority start.
   logic             m_pend;
   logic [WIDTH-1:0] m_data;
   int               m_id;
   logic             m_err;
   int               m_ptr;

   typedef struct {
      int         idx;
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp;
      logic       err;
   } vec_t;

   vec_t vecs[9];

   always #5 clk = ~clk;

   logic_op_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_err   (rsp_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_op(input int op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      case (op)
         0: return a & b;
         1: return a | b;
         2: return a ^ b;
         3: return ~(a & b);
         4: return ~(a | b);
         5: return ~(a ^ b);
         6: return ~a;
         default: return '0;
      endcase
   endfunction

   // Expected grant index, or -1 when no requester may be accepted this cycle.
   function automatic int ref_grant();
      int i;
      if (!rst_n) return -1;
      if (m_pend && !rsp_ready) return -1;
      for (int k = 0; k < NUM_REQ; k++) begin
         i = (m_ptr + k) % NUM_REQ;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_pend = 1'b0;
      m_data = '0;
      m_id   = 0;
      m_err  = 1'b0;
      m_ptr  = 0;
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      req_op[i*3 +: 3]         = op;
      req_a[i*WIDTH +: WIDTH]  = a;
      req_b[i*WIDTH +: WIDTH]  = b;
   endtask

   // Called just after a rising edge with inputs applied; returns just after the next edge.
   task automatic cycle(input string tag);
      int                 g;
      logic [NUM_REQ-1:0] exp_rdy;
      logic [WIDTH-1:0]   nd;
      logic               ne;
      #1;
      g       = ref_grant();
      exp_rdy = '0;
      nd      = '0;
      ne      = 1'b0;
      if (g >= 0) begin
         exp_rdy[g] = 1'b1;
         nd = ref_op(int'(req_op[g*3 +: 3]), req_a[g*WIDTH +: WIDTH], req_b[g*WIDTH +: WIDTH]);
         ne = (req_op[g*3 +: 3] == 3'd7);
      end
      chk({tag, "_req_ready"}, 32'(req_ready), 32'(exp_rdy));
      @(posedge clk);
      if (g >= 0) begin
         m_pend = 1'b1;
         m_data = nd;
         m_err  = ne;
         m_id   = g;
`ifdef LOGIC_ARB_RR_EN
         m_ptr  = (g + 1) % NUM_REQ;
`endif
      end else if (m_pend && rsp_ready) begin
         m_pend = 1'b0;
      end
      #1;
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(m_pend));
      if (m_pend) begin
         chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(m_data));
         chk({tag, "_rsp_id"},   32'(rsp_id),   32'(m_id));
         chk({tag, "_rsp_err"},  32'(rsp_err),  32'(m_err));
      end
   endtask

   initial begin
      int               exp_g[5];
      logic [WIDTH-1:0] held;

      vecs[0] = '{2, 3'd2, 8'hF0, 8'h3C, 8'hCC, 1'b0};
      vecs[1] = '{0, 3'd0, 8'hA5, 8'h0F, 8'h05, 1'b0};
      vecs[2] = '{1, 3'd1, 8'hA5, 8'h0F, 8'hAF, 1'b0};
      vecs[3] = '{2, 3'd2, 8'hA5, 8'h0F, 8'hAA, 1'b0};
      vecs[4] = '{3, 3'd3, 8'hA5, 8'h0F, 8'hFA, 1'b0};
      vecs[5] = '{0, 3'd4, 8'hA5, 8'h0F, 8'h50, 1'b0};
      vecs[6] = '{1, 3'd5, 8'hA5, 8'h0F, 8'h55, 1'b0};
      vecs[7] = '{2, 3'd6, 8'hA5, 8'h0F, 8'h5A, 1'b0};
      vecs[8] = '{3, 3'd7, 8'hA5, 8'h0F, 8'h00, 1'b1};
`ifdef LOGIC_ARB_RR_EN
      exp_g = '{0, 1, 2, 3, 0};
`else
      exp_g = '{0, 0, 0, 0, 0};
`endif

      // Reset: no grant even with all requests valid, outputs cleared.
      model_reset();
      rst_n     = 1'b0;
      rsp_ready = 1'b0;
      req_valid = '1;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      #2;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_data",  32'(rsp_data),  32'h0);
      chk("rst_rsp_id",    32'(rsp_id),    32'h0);
      chk("rst_rsp_err",   32'(rsp_err),   32'h0);
      req_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("post_rst_req_ready", 32'(req_ready), 32'h0);
      chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
      @(posedge clk); #1;

      // Contention with all requesters valid and downstream always ready.
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'(i), 8'(8'h11 * (i + 1)), 8'h3C);
      req_valid = '1;
      rsp_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         cycle("contend");
         chk("contend_grant_order", 32'(rsp_id), 32'(exp_g[n]));
      end
      req_valid = '0;
      cycle("contend_drain");

      // Table vectors: single op and every opcode, issued back-to-back.
      for (int v = 0; v < 9; v++) begin
         req_valid = '0;
         set_req(vecs[v].idx, vecs[v].op, vecs[v].a, vecs[v].b);
         req_valid[vecs[v].idx] = 1'b1;
         rsp_ready = 1'b1;
         cycle("vec");
         chk($sformatf("vec%0d_data", v), 32'(rsp_data), 32'(vecs[v].exp));
         chk($sformatf("vec%0d_err", v),  32'(rsp_err),  32'(vecs[v].err));
         chk($sformatf("vec%0d_id", v),   32'(rsp_id),   32'(vecs[v].idx));
      end
      req_valid = '0;
      cycle("vec_drain");

      // Backpressure: result held stable, no grants, then grant on the release cycle.
      set_req(1, 3'd1, 8'h12, 8'h40);
      req_valid = 4'b0010;
      rsp_ready = 1'b1;
      cycle("bp_load");
      held      = rsp_data;
      req_valid = '1;
      rsp_ready = 1'b0;
      for (int n = 0; n < 3; n++) begin
         cycle("bp_hold");
         chk("bp_data_stable", 32'(rsp_data), 32'(held));
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_grant", 32'(|req_ready), 32'h1);
      cycle("bp_release");

      // Mid-operation reset while HOLD with a pending result.
      set_req(1, 3'd0, 8'hFF, 8'h0F);
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      cycle("mid_load");
      chk("mid_in_hold", 32'(rsp_valid), 32'h1);
      req_valid = '1;
      rst_n     = 1'b0;
      #1;
      chk("mid_rst_valid",     32'(rsp_valid), 32'h0);
      chk("mid_rst_data",      32'(rsp_data),  32'h0);
      chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      rsp_ready = 1'b1;
      cycle("mid_post");
      chk("mid_ptr_zero", 32'(rsp_id), 32'h0);

      // Random traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         req_valid = NUM_REQ'($urandom);
         req_op    = (NUM_REQ*3)'($urandom);
         req_a     = (NUM_REQ*WIDTH)'($urandom);
         req_b     = (NUM_REQ*WIDTH)'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         cycle("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
